// File: rtl/instr_decoder_if.sv
// Program-memory fetch bus between instr_decoder (master) and instruction memory (slave),
// plus the shared ALU function / operand-select encodings.
`ifndef INSTR_DECODER_DEFS
`define INSTR_DECODER_DEFS
`define RA     3'b000
`define RB     3'b001
`define RADD   3'b010
`define RSUB   3'b011
`define RAND   3'b100
`define ROR    3'b101
`define RXOR   3'b110
`define RNOT   3'b111
`define REG    2'b00
`define SW_7_0 2'b01
`define SW_8   2'b10
`define IMM    2'b11
`endif

interface instr_decoder_if #(
  parameter int PC_W = 8
);
  logic            instr_req;
  logic [PC_W-1:0] pc;
  logic [15:0]     instr;
  logic            instr_valid;

  modport master (
    output instr_req,
    output pc,
    input  instr,
    input  instr_valid
  );

  modport slave (
    input  instr_req,
    input  pc,
    output instr,
    output instr_valid
  );
endinterface

// File: rtl/instr_decoder.sv
// Multi-cycle fetch/decode/execute controller driving ALU controls from 16-bit instructions.
// Define INSTR_DECODER_TRAP_EN to trap illegal SYS opcodes (adds the 'illegal' output).
module instr_decoder #(
  parameter int n    = 8,
  parameter int PC_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  instr_decoder_if.master       mem,
  output logic [2:0]            func,
  output logic [1:0]            a_sel,
  output logic [1:0]            b_sel,
  output logic [n-1:0]          immidiate,
  output logic [2:0]            ra_addr,
  output logic [2:0]            rb_addr,
  output logic [2:0]            rd_addr,
  output logic                  reg_we,
  input  logic [3:0]            alu_flags,
  output logic [3:0]            flags_q,
  output logic                  halted
`ifdef INSTR_DECODER_TRAP_EN
  ,
  output logic                  illegal
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
`ifdef INSTR_DECODER_TRAP_EN
    ,
    S_TRAP
`endif
  } state_e;

  localparam logic [1:0] OP_ALU_R = 2'b00;
  localparam logic [1:0] OP_ALU_I = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_SYS   = 2'b11;

  localparam logic [1:0] SYS_NOP  = 2'b00;
  localparam logic [1:0] SYS_HALT = 2'b01;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [3:0]      flags_d;

  logic [1:0]      ir_op;
  logic [2:0]      ir_func;
  logic [2:0]      ir_rd;
  logic [2:0]      ir_ra;
  logic [2:0]      ir_rb;
  logic [1:0]      ir_asel;
  logic [7:0]      ir_imm;
  logic [1:0]      ir_sys;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] pc_br;
  logic            br_taken;
  logic            alu_phase;

  assign ir_op   = ir_q[15:14];
  assign ir_func = ir_q[13:11];
  assign ir_rd   = ir_q[10:8];
  assign ir_ra   = ir_q[7:5];
  assign ir_rb   = ir_q[4:2];
  assign ir_asel = ir_q[1:0];
  assign ir_imm  = ir_q[7:0];
  assign ir_sys  = ir_q[13:12];

  // Offset is sign-extended from 8 bits then cut to PC_W; the add wraps naturally.
  assign pc_inc  = pc_q + PC_W'(1);
  assign off_ext = PC_W'($signed(ir_imm));
  assign pc_br   = pc_inc + off_ext;

  // Condition field shares bits [13:11] with the ALU function; flags are {V,N,Z,C}.
  always_comb begin
    br_taken = 1'b0;
    case (ir_func)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = flags_q[1];
      3'b010:  br_taken = ~flags_q[1];
      3'b011:  br_taken = flags_q[0];
      3'b100:  br_taken = flags_q[2];
      3'b101:  br_taken = flags_q[3];
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem.instr_valid) begin
          ir_d    = mem.instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (ir_op)
          OP_ALU_R, OP_ALU_I: begin
            state_d = S_EXEC;
          end
          OP_BR: begin
            pc_d    = br_taken ? pc_br : pc_inc;
            state_d = S_FETCH;
          end
          default: begin
            if (ir_sys == SYS_HALT) begin
              state_d = S_HALT;
            end else if (ir_sys == SYS_NOP) begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end else begin
`ifdef INSTR_DECODER_TRAP_EN
              state_d = S_TRAP;
`else
              pc_d    = pc_inc;
              state_d = S_FETCH;
`endif
            end
          end
        endcase
      end
      S_EXEC: begin
        flags_d = alu_flags;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
`ifdef INSTR_DECODER_TRAP_EN
      S_TRAP: begin
        state_d = S_TRAP;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign alu_phase = (state_q == S_DECODE) || (state_q == S_EXEC);

  always_comb begin
    func      = `RA;
    a_sel     = `REG;
    b_sel     = `REG;
    immidiate = '0;
    ra_addr   = 3'd0;
    rb_addr   = 3'd0;
    rd_addr   = 3'd0;
    if (alu_phase) begin
      if (ir_op == OP_ALU_R) begin
        func    = ir_func;
        rd_addr = ir_rd;
        ra_addr = ir_ra;
        rb_addr = ir_rb;
        a_sel   = ir_asel;
      end else if (ir_op == OP_ALU_I) begin
        func      = ir_func;
        rd_addr   = ir_rd;
        ra_addr   = ir_rd;
        b_sel     = `IMM;
        immidiate = n'(ir_imm);
      end
    end
  end

  // Reset in the EXEC cycle must suppress the write strobe in that same cycle.
  assign reg_we        = (state_q == S_EXEC) && !reset;
  assign mem.instr_req = (state_q == S_FETCH);
  assign mem.pc        = pc_q;
  assign halted        = (state_q == S_HALT);
`ifdef INSTR_DECODER_TRAP_EN
  assign illegal       = (state_q == S_TRAP);
`endif

endmodule
